// File: rtl/dino_motion_if.sv
// Frame-rate control and motion bus between the game logic and the dino motion engine.
interface dino_motion_if #(
  parameter int Y_W = 11,
  parameter int V_W = 7
);
  logic [1:0]            gameState;
  logic                  jump;
  logic                  duck;
  logic [Y_W-1:0]        GroundY;
  logic signed [Y_W-1:0] DinoY;
  logic signed [V_W-1:0] velocity;
  logic [1:0]            motionState;
  logic                  onGround;
  logic                  airborne;
  logic                  landed;

  modport master (
    output gameState, jump, duck, GroundY,
    input  DinoY, velocity, motionState, onGround, airborne, landed
  );

  modport slave (
    input  gameState, jump, duck, GroundY,
    output DinoY, velocity, motionState, onGround, airborne, landed
  );
endinterface

// File: rtl/dino_motion_ctrl.sv
// Per-frame vertical motion for the dino: launch, held-jump lift, fast-fall,
// terminal velocity, landing detection and a short mid-air jump buffer.
module dino_motion_ctrl #(
  parameter int Y_W        = 11,
  parameter int V_W        = 7,
  parameter int V_INIT     = 17,
  parameter int G_HOLD     = 1,
  parameter int G_NORM     = 2,
  parameter int G_FAST     = 4,
  parameter int V_MAX      = 12,
  parameter int HOLD_MAX   = 8,
  parameter int BUF_FRAMES = 3
) (
  input  logic          FrameClk,
  input  logic          rst,
  dino_motion_if.slave  bus
);
  localparam int HC_W = $clog2(HOLD_MAX + 1);
  localparam int BF_W = $clog2(BUF_FRAMES + 1);

  localparam logic signed [V_W:0]   G_HOLD_S = (V_W+1)'(G_HOLD);
  localparam logic signed [V_W:0]   G_NORM_S = (V_W+1)'(G_NORM);
  localparam logic signed [V_W:0]   G_FAST_S = (V_W+1)'(G_FAST);
  localparam logic signed [V_W:0]   VMAX_S   = (V_W+1)'(V_MAX);
  localparam logic signed [V_W:0]   VMIN_S   = (V_W+1)'(-(2**(V_W-1)));
  localparam logic signed [V_W-1:0] V_LAUNCH = V_W'(-V_INIT);
  localparam logic [HC_W-1:0]       HOLD_LIM = HC_W'(HOLD_MAX);
  localparam logic [BF_W-1:0]       BUF_INIT = BF_W'(BUF_FRAMES);

  typedef enum logic [1:0] {GROUNDED = 2'b00, RISING = 2'b01, FALLING = 2'b10} mstate_t;

  mstate_t               state, n_state;
  logic signed [Y_W-1:0] dino_y, n_y;
  logic signed [V_W-1:0] vel, n_v;
  logic [HC_W-1:0]       hold_cnt, n_hold_cnt;
  logic                  hold_off, n_hold_off;
  logic [BF_W-1:0]       buf_cnt, n_buf;
  logic                  jump_d;
  logic                  landed_q, n_landed;

  logic                  jump_edge;
  logic signed [Y_W:0]   y_sum, gnd_ext;
  logic signed [V_W:0]   g, v_sum, v_clamp;

  always_ff @(posedge FrameClk) begin
    if (rst) begin
      state    <= GROUNDED;
      dino_y   <= bus.GroundY;
      vel      <= '0;
      hold_cnt <= '0;
      hold_off <= 1'b0;
      buf_cnt  <= '0;
      jump_d   <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state    <= n_state;
      dino_y   <= n_y;
      vel      <= n_v;
      hold_cnt <= n_hold_cnt;
      hold_off <= n_hold_off;
      buf_cnt  <= n_buf;
      jump_d   <= bus.jump;
      landed_q <= n_landed;
    end
  end

  always_comb begin
    n_state    = state;
    n_y        = dino_y;
    n_v        = vel;
    n_hold_cnt = hold_cnt;
    n_hold_off = hold_off;
    n_buf      = buf_cnt;
    n_landed   = 1'b0;

    jump_edge = bus.jump & ~jump_d;
    // Sums carry one extra bit so the landing test and clamp never see a wrapped value.
    y_sum   = {dino_y[Y_W-1], dino_y} + {{(Y_W+1-V_W){vel[V_W-1]}}, vel};
    gnd_ext = {1'b0, bus.GroundY};

    g = G_NORM_S;
    if (bus.duck)
      g = G_FAST_S;
    else if (state == RISING && bus.jump && !hold_off && hold_cnt < HOLD_LIM)
      g = G_HOLD_S;

    v_sum = {vel[V_W-1], vel} + g;
    if (v_sum > VMAX_S)      v_clamp = VMAX_S;
    else if (v_sum < VMIN_S) v_clamp = VMIN_S;
    else                     v_clamp = v_sum;

    case (bus.gameState)
      2'b00: begin
        n_y     = bus.GroundY;
        n_v     = '0;
        n_state = GROUNDED;
        n_buf   = '0;
      end
      2'b10: begin
        if (state == GROUNDED) begin
          n_y = bus.GroundY;
          if (bus.jump || buf_cnt != '0) begin
            n_v        = V_LAUNCH;
            n_y        = bus.GroundY - Y_W'(V_INIT);
            n_hold_cnt = '0;
            n_hold_off = 1'b0;
            n_buf      = '0;
            n_state    = RISING;
          end
        end else begin
          n_y = y_sum[Y_W-1:0];
          n_v = v_clamp[V_W-1:0];
          if (state == RISING) begin
            if (hold_cnt < HOLD_LIM) n_hold_cnt = hold_cnt + 1'b1;
            if (!bus.jump)           n_hold_off = 1'b1;
            if (!v_sum[V_W])         n_state    = FALLING;
          end
          if (jump_edge)             n_buf = BUF_INIT;
          else if (buf_cnt != '0)    n_buf = buf_cnt - 1'b1;
          // Touching the ground wins over whatever the rise/fall rules chose.
          if (y_sum >= gnd_ext) begin
            n_y      = bus.GroundY;
            n_v      = '0;
            n_state  = GROUNDED;
            n_landed = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.DinoY       = dino_y;
  assign bus.velocity    = vel;
  assign bus.motionState = state;
  assign bus.onGround    = (state == GROUNDED);
  assign bus.airborne    = (state != GROUNDED);
  assign bus.landed      = landed_q;
endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed jump scenarios plus randomized frames checked against a frame-level motion model.
module tb_dino_motion_ctrl;
  localparam int Y_W = 11, V_W = 7, V_INIT = 17, G_HOLD = 1, G_NORM = 2, G_FAST = 4;
  localparam int V_MAX = 12, HOLD_MAX = 8, BUF_FRAMES = 3;

  logic FrameClk = 1'b0;
  logic rst;
  always #5 FrameClk = ~FrameClk;

  dino_motion_if #(.Y_W(Y_W), .V_W(V_W)) bus();

  dino_motion_ctrl #(
    .Y_W(Y_W), .V_W(V_W), .V_INIT(V_INIT), .G_HOLD(G_HOLD), .G_NORM(G_NORM),
    .G_FAST(G_FAST), .V_MAX(V_MAX), .HOLD_MAX(HOLD_MAX), .BUF_FRAMES(BUF_FRAMES)
  ) dut (.FrameClk(FrameClk), .rst(rst), .bus(bus));

  int n_checks = 0, n_errors = 0;
  int t2_frames;

  // Model: mode 0 ground, 1 rising, 2 falling.
  int m_y, m_v, m_mode, m_hold, m_buf;
  bit m_hoff, m_jd, m_landed;

  task automatic model_step(input bit r, input int gs, input bit j, input bit d, input int gy);
    int g, ny, nv;
    bit je;
    je = j && !m_jd;
    m_landed = 0;
    if (r) begin
      m_y = gy; m_v = 0; m_mode = 0; m_hold = 0; m_hoff = 0; m_buf = 0; m_jd = 0;
      return;
    end
    if (gs == 0) begin
      m_y = gy; m_v = 0; m_mode = 0; m_buf = 0;
    end else if (gs == 2) begin
      if (m_mode == 0) begin
        m_y = gy;
        if (j || m_buf > 0) begin
          m_v = -V_INIT; m_y = gy - V_INIT; m_hold = 0; m_hoff = 0; m_buf = 0; m_mode = 1;
        end
      end else begin
        if (d) g = G_FAST;
        else if (m_mode == 1 && j && !m_hoff && m_hold < HOLD_MAX) g = G_HOLD;
        else g = G_NORM;
        ny = m_y + m_v;
        nv = (m_v + g > V_MAX) ? V_MAX : m_v + g;
        if (m_mode == 1) begin
          if (m_hold < HOLD_MAX) m_hold++;
          if (!j) m_hoff = 1;
          if (m_v + g >= 0) m_mode = 2;
        end
        m_buf = je ? BUF_FRAMES : (m_buf > 0 ? m_buf - 1 : 0);
        if (ny >= gy) begin
          m_y = gy; m_v = 0; m_mode = 0; m_landed = 1;
        end else begin
          m_y = ny; m_v = nv;
        end
      end
    end
    m_jd = j;
  endtask

  task automatic frame(input bit r, input logic [1:0] gs, input bit j, input bit d, input int gy);
    logic [Y_W-1:0] gyv;
    gyv = gy[Y_W-1:0];
    rst = r; bus.gameState = gs; bus.jump = j; bus.duck = d; bus.GroundY = gyv;
    model_step(r, int'(gs), j, d, gy);
    @(posedge FrameClk);
    #1;
  endtask

  function automatic int dy();
    return int'($signed(bus.DinoY));
  endfunction
  function automatic int dv();
    return int'($signed(bus.velocity));
  endfunction

  task automatic test_reset();
    frame(1, 2'b10, 0, 0, 200);
    frame(1, 2'b10, 0, 0, 200);
    n_checks++; if (dy() !== 200) begin n_errors++; $display("FAIL reset_y got %0d exp 200", dy()); end
    n_checks++; if (dv() !== 0) begin n_errors++; $display("FAIL reset_v got %0d exp 0", dv()); end
    n_checks++; if (bus.onGround !== 1'b1 || bus.airborne !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags got on=%b air=%b exp 1/0", bus.onGround, bus.airborne); end
    n_checks++; if (bus.landed !== 1'b0) begin n_errors++; $display("FAIL reset_landed got %b exp 0", bus.landed); end
    n_checks++; if (bus.motionState !== 2'b00) begin
      n_errors++; $display("FAIL reset_state got %b exp 00", bus.motionState); end
  endtask

  task automatic test_single_jump();
    int exp_y [10] = '{183, 166, 151, 138, 127, 118, 111, 106, 103, 102};
    int vmax, lcnt, nfr;
    frame(1, 2'b10, 0, 0, 200);
    frame(0, 2'b10, 1, 0, 200);
    nfr = 1;
    n_checks++; if (dy() !== 183 || bus.motionState !== 2'b01) begin
      n_errors++; $display("FAIL launch got y=%0d st=%b exp 183/01", dy(), bus.motionState); end
    for (int k = 1; k < 10; k++) begin
      frame(0, 2'b10, 0, 0, 200);
      nfr++;
      n_checks++; if (dy() !== exp_y[k]) begin
        n_errors++; $display("FAIL rise_y[%0d] got %0d exp %0d", k, dy(), exp_y[k]); end
    end
    vmax = -100; lcnt = 0;
    for (int k = 0; k < 60 && lcnt == 0; k++) begin
      frame(0, 2'b10, 0, 0, 200);
      nfr++;
      if (dv() > vmax) vmax = dv();
      if (bus.landed === 1'b1) begin
        lcnt++;
        n_checks++; if (dy() !== 200 || bus.onGround !== 1'b1) begin
          n_errors++; $display("FAIL land_y got %0d exp 200", dy()); end
      end
    end
    t2_frames = nfr;
    n_checks++; if (lcnt !== 1) begin n_errors++; $display("FAIL land_seen got %0d exp 1", lcnt); end
    n_checks++; if (vmax !== V_MAX) begin n_errors++; $display("FAIL vmax got %0d exp %0d", vmax, V_MAX); end
    n_checks++; if (nfr !== 22) begin n_errors++; $display("FAIL land_frame got %0d exp 22", nfr); end
    frame(0, 2'b10, 0, 0, 200);
    n_checks++; if (bus.landed !== 1'b0 || dy() !== 200) begin
      n_errors++; $display("FAIL land_pulse got landed=%b y=%0d exp 0/200", bus.landed, dy()); end
  endtask

  task automatic test_hold_jump();
    int miny, pv, lcnt;
    frame(1, 2'b10, 0, 0, 200);
    frame(0, 2'b10, 1, 0, 200);
    miny = dy();
    for (int k = 1; k <= 9; k++) begin
      frame(0, 2'b10, 1, 0, 200);
      if (dy() < miny) miny = dy();
      if (k <= HOLD_MAX) begin
        n_checks++; if (dv() !== -V_INIT + k * G_HOLD) begin
          n_errors++; $display("FAIL hold_v[%0d] got %0d exp %0d", k, dv(), -V_INIT + k * G_HOLD); end
      end
    end
    n_checks++; if (dv() !== -V_INIT + HOLD_MAX * G_HOLD + G_NORM) begin
      n_errors++; $display("FAIL hold_expire got %0d exp %0d", dv(), -V_INIT + HOLD_MAX * G_HOLD + G_NORM); end
    frame(0, 2'b10, 0, 0, 200);
    for (int k = 0; k < 3; k++) begin
      pv = dv();
      frame(0, 2'b10, 1, 0, 200);
      if (dy() < miny) miny = dy();
      n_checks++; if (dv() - pv !== G_NORM) begin
        n_errors++; $display("FAIL no_reextend[%0d] got dv=%0d exp %0d", k, dv() - pv, G_NORM); end
    end
    lcnt = 0;
    for (int k = 0; k < 60 && lcnt == 0; k++) begin
      frame(0, 2'b10, 0, 0, 200);
      if (dy() < miny) miny = dy();
      if (bus.landed === 1'b1) lcnt++;
    end
    n_checks++; if (!(miny < 102) || lcnt != 1) begin
      n_errors++; $display("FAIL hold_apex got apex=%0d landed=%0d exp <102/1", miny, lcnt); end
  endtask

  task automatic test_fast_fall();
    int exp_v [4] = '{7, 11, 12, 12};
    int nfr, lcnt;
    frame(1, 2'b10, 0, 0, 200);
    frame(0, 2'b10, 1, 0, 200);
    nfr = 1;
    for (int k = 0; k < 30 && !(m_mode == 2 && m_v == 3); k++) begin
      frame(0, 2'b10, 0, 0, 200); nfr++;
    end
    n_checks++; if (dv() !== 3 || bus.motionState !== 2'b10) begin
      n_errors++; $display("FAIL fall_v3 got v=%0d st=%b exp 3/10", dv(), bus.motionState); end
    lcnt = 0;
    for (int k = 0; k < 4; k++) begin
      frame(0, 2'b10, 0, 1, 200); nfr++;
      n_checks++; if (dv() !== exp_v[k]) begin
        n_errors++; $display("FAIL duck_v[%0d] got %0d exp %0d", k, dv(), exp_v[k]); end
    end
    for (int k = 0; k < 40 && lcnt == 0; k++) begin
      frame(0, 2'b10, 0, 1, 200); nfr++;
      if (bus.landed === 1'b1) lcnt++;
    end
    n_checks++; if (lcnt != 1 || !(nfr < t2_frames)) begin
      n_errors++; $display("FAIL duck_land got frame=%0d landed=%0d exp <%0d/1", nfr, lcnt, t2_frames); end
  endtask

  task automatic test_jump_buffer();
    bit found;
    frame(1, 2'b10, 0, 0, 200);
    frame(0, 2'b10, 1, 0, 200);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      frame(0, 2'b10, 0, 0, 200);
      found = (m_mode == 2 && m_y == 174);
    end
    frame(0, 2'b10, 1, 0, 200);
    frame(0, 2'b10, 0, 0, 200);
    frame(0, 2'b10, 0, 0, 200);
    n_checks++; if (!found || bus.landed !== 1'b1 || dy() !== 200) begin
      n_errors++; $display("FAIL buf_land got landed=%b y=%0d exp 1/200", bus.landed, dy()); end
    frame(0, 2'b10, 0, 0, 200);
    n_checks++; if (dy() !== 183 || bus.motionState !== 2'b01) begin
      n_errors++; $display("FAIL buf_fire got y=%0d st=%b exp 183/01", dy(), bus.motionState); end
  endtask

  task automatic test_freeze();
    int cy, cv;
    frame(1, 2'b10, 0, 0, 200);
    frame(0, 2'b10, 1, 0, 200);
    for (int k = 0; k < 3; k++) frame(0, 2'b10, 0, 0, 200);
    cy = 138; cv = -11;
    n_checks++; if (dy() !== cy || dv() !== cv) begin
      n_errors++; $display("FAIL pre_freeze got %0d/%0d exp %0d/%0d", dy(), dv(), cy, cv); end
    for (int k = 0; k < 6; k++) begin
      frame(0, (k < 4) ? 2'b01 : 2'b11, k[0], k[1], 200);
      n_checks++; if (dy() !== cy || dv() !== cv || bus.motionState !== 2'b01) begin
        n_errors++; $display("FAIL freeze[%0d] got %0d/%0d exp %0d/%0d", k, dy(), dv(), cy, cv); end
    end
    frame(0, 2'b10, 0, 0, 200);
    n_checks++; if (dy() !== cy + cv || dv() !== m_v) begin
      n_errors++; $display("FAIL resume got %0d/%0d exp %0d/%0d", dy(), dv(), cy + cv, m_v); end
    frame(0, 2'b00, 1, 0, 200);
    n_checks++; if (dy() !== 200 || dv() !== 0 || bus.onGround !== 1'b1) begin
      n_errors++; $display("FAIL idle_snap got %0d/%0d exp 200/0", dy(), dv()); end
    frame(0, 2'b10, 1, 0, 200);
    frame(0, 2'b10, 1, 0, 200);
    frame(1, 2'b10, 1, 0, 190);
    n_checks++; if (dy() !== 190 || dv() !== 0 || bus.motionState !== 2'b00 || bus.landed !== 1'b0) begin
      n_errors++; $display("FAIL rst_midair got %0d/%0d st=%b exp 190/0/00", dy(), dv(), bus.motionState); end
  endtask

  task automatic test_random();
    int gy;
    bit r, j, d;
    logic [1:0] gs;
    gy = 200;
    frame(1, 2'b10, 0, 0, gy);
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 149) == 0);
      gs = ($urandom_range(0, 9) < 8) ? 2'b10 : 2'($urandom_range(0, 3));
      j  = ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 24) == 0) gy = $urandom_range(150, 260);
      frame(r, gs, j, d, gy);
      n_checks++; if (dy() !== m_y) begin
        n_errors++; $display("FAIL rnd_y[%0d] got %0d exp %0d", k, dy(), m_y); end
      n_checks++; if (dv() !== m_v) begin
        n_errors++; $display("FAIL rnd_v[%0d] got %0d exp %0d", k, dv(), m_v); end
      n_checks++; if (int'(bus.motionState) !== m_mode) begin
        n_errors++; $display("FAIL rnd_state[%0d] got %0d exp %0d", k, bus.motionState, m_mode); end
      n_checks++; if (bus.landed !== m_landed || bus.onGround !== (m_mode == 0) || bus.airborne !== (m_mode != 0)) begin
        n_errors++; $display("FAIL rnd_flags[%0d] got l=%b g=%b a=%b exp l=%b mode=%0d",
                             k, bus.landed, bus.onGround, bus.airborne, m_landed, m_mode); end
    end
  endtask

  initial begin
    rst = 1'b1; bus.gameState = 2'b00; bus.jump = 1'b0; bus.duck = 1'b0; bus.GroundY = 11'd200;
    m_y = 200; m_v = 0; m_mode = 0; m_hold = 0; m_buf = 0; m_hoff = 0; m_jd = 0; m_landed = 0;
    t2_frames = 0;
    @(posedge FrameClk); #1;
    test_reset();
    test_single_jump();
    test_hold_jump();
    test_fast_fall();
    test_jump_buffer();
    test_freeze();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
